// File: rtl/apb_master.sv
// APB requester: turns single valid/ready commands into APB SETUP/ACCESS transfers
// and returns read data plus error/timeout status on a valid/ready response port.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // The counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_r,       state_nxt_s;
    logic                    psel_r,        psel_nxt_s;
    logic                    penable_r,     penable_nxt_s;
    logic                    pwrite_r,      pwrite_nxt_s;
    logic [ADDR_WIDTH-1:0]   paddr_r,       paddr_nxt_s;
    logic [DATA_WIDTH-1:0]   pwdata_r,      pwdata_nxt_s;
    logic [STRB_WIDTH-1:0]   pstrb_r,       pstrb_nxt_s;
    logic                    rsp_valid_r,   rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r,   rsp_rdata_nxt_s;
    logic                    rsp_err_r,     rsp_err_nxt_s;
    logic                    rsp_timeout_r, rsp_timeout_nxt_s;
    logic [CNT_WIDTH-1:0]    wait_cnt_r,    wait_cnt_nxt_s;
    logic                    accept_s;

    assign accept_s = cmd_valid && (state_r == ST_IDLE);

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_nxt_s       = state_r;
        psel_nxt_s        = psel_r;
        penable_nxt_s     = penable_r;
        pwrite_nxt_s      = pwrite_r;
        paddr_nxt_s       = paddr_r;
        pwdata_nxt_s      = pwdata_r;
        pstrb_nxt_s       = pstrb_r;
        rsp_valid_nxt_s   = rsp_valid_r;
        rsp_rdata_nxt_s   = rsp_rdata_r;
        rsp_err_nxt_s     = rsp_err_r;
        rsp_timeout_nxt_s = rsp_timeout_r;
        wait_cnt_nxt_s    = wait_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    pwrite_nxt_s  = cmd_write;
                    paddr_nxt_s   = cmd_addr;
                    pwdata_nxt_s  = cmd_wdata;
                    pstrb_nxt_s   = cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}};
                    psel_nxt_s    = 1'b1;
                    penable_nxt_s = 1'b0;
                    state_nxt_s   = ST_SETUP;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end

            ST_SETUP: begin
                penable_nxt_s  = 1'b1;
                wait_cnt_nxt_s = {CNT_WIDTH{1'b0}};
                state_nxt_s    = ST_ACCESS;
            end

            ST_ACCESS: begin
                // PREADY is checked first so a ready on the limit cycle completes normally.
                if (PREADY) begin
                    psel_nxt_s        = 1'b0;
                    penable_nxt_s     = 1'b0;
                    rsp_rdata_nxt_s   = pwrite_r ? {DATA_WIDTH{1'b0}} : PRDATA;
                    rsp_err_nxt_s     = PSLVERR;
                    rsp_timeout_nxt_s = 1'b0;
                    rsp_valid_nxt_s   = 1'b1;
                    state_nxt_s       = ST_RESP;
                end else if (TIMEOUT_EN && (wait_cnt_r == CNT_LIMIT)) begin
                    psel_nxt_s        = 1'b0;
                    penable_nxt_s     = 1'b0;
                    rsp_rdata_nxt_s   = {DATA_WIDTH{1'b0}};
                    rsp_err_nxt_s     = 1'b1;
                    rsp_timeout_nxt_s = 1'b1;
                    rsp_valid_nxt_s   = 1'b1;
                    state_nxt_s       = ST_RESP;
                end else begin
                    wait_cnt_nxt_s    = wait_cnt_r + CNT_WIDTH'(1);
                    state_nxt_s       = ST_ACCESS;
                end
            end

            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s     = ST_RESP;
                end
            end

            default: begin
                psel_nxt_s      = 1'b0;
                penable_nxt_s   = 1'b0;
                rsp_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority in every state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r       <= ST_IDLE;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_WIDTH{1'b0}};
            pwdata_r      <= {DATA_WIDTH{1'b0}};
            pstrb_r       <= {STRB_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            wait_cnt_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            psel_r        <= psel_nxt_s;
            penable_r     <= penable_nxt_s;
            pwrite_r      <= pwrite_nxt_s;
            paddr_r       <= paddr_nxt_s;
            pwdata_r      <= pwdata_nxt_s;
            pstrb_r       <= pstrb_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            rsp_err_r     <= rsp_err_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
        end
    end

    assign cmd_ready   = (state_r == ST_IDLE) && !PRESET;
    assign PSEL        = psel_r;
    assign PENABLE     = penable_r;
    assign PWRITE      = pwrite_r;
    assign PADDR       = paddr_r;
    assign PWDATA      = pwdata_r;
    assign PSTRB       = pstrb_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule
